// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// Signal prefixes are from the unit's point of view.
interface mul_div_unit_if #(
   parameter int DATA_W = 32
);
   logic              i_op_valid;
   logic [3:0]        i_op;
   logic [DATA_W-1:0] i_opr1;
   logic [DATA_W-1:0] i_opr2;
   logic              i_cancel;
   logic              o_ready;
   logic              o_busy;
   logic              o_done;
   logic [DATA_W-1:0] o_hi;
   logic [DATA_W-1:0] o_lo;

   modport master (
      output i_op_valid, i_op, i_opr1, i_opr2, i_cancel,
      input  o_ready, o_busy, o_done, o_hi, o_lo
   );

   modport slave (
      input  i_op_valid, i_op, i_opr1, i_opr2, i_cancel,
      output o_ready, o_busy, o_done, o_hi, o_lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// HI/LO owning multiply/divide unit: pipelined multiply with accumulate,
// restoring 1-bit/cycle divider, MTHI/MTLO, cancel-on-flush.
module mul_div_unit #(
   parameter int DATA_W     = 32,
   parameter int MUL_STAGES = 2
) (
   input logic             i_clk,
   input logic             i_rst,
   mul_div_unit_if.slave   bus
);
   localparam int PW    = 2 * DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 2);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WR} state_t;

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_op;
   logic [DATA_W-1:0] r_a, r_b, r_rem, r_opr1, r_hi, r_lo;
   logic              r_neg_q, r_neg_r, r_dvz, r_done;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_is_mul, w_is_div, w_is_wr, w_sgn, w_accept, w_fin, w_write;
   logic [DATA_W-1:0] w_abs1, w_abs2;

   assign w_is_mul = bus.i_op inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8};
   assign w_is_div = bus.i_op inside {4'd3, 4'd4};
   assign w_is_wr  = bus.i_op inside {4'd9, 4'd10};
   // odd opcodes in 1..8 are the signed variants
   assign w_sgn    = bus.i_op[0] && (w_is_mul || w_is_div);
   assign w_accept = bus.i_op_valid && (r_state == S_IDLE) && !bus.i_cancel
                     && (w_is_mul || w_is_div || w_is_wr);
   assign w_abs1   = (w_sgn && bus.i_opr1[DATA_W-1]) ? -bus.i_opr1 : bus.i_opr1;
   assign w_abs2   = (w_sgn && bus.i_opr2[DATA_W-1]) ? -bus.i_opr2 : bus.i_opr2;

   // multiply: magnitude product, sign fixup, then MUL_STAGES-1 register stages
   logic [PW-1:0] w_prod_u, w_prod, w_acc, w_mul_res;
   logic [PW-1:0] w_pst [MUL_STAGES];

   assign w_prod_u = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
   assign w_prod   = r_neg_q ? -w_prod_u : w_prod_u;
   assign w_pst[0] = w_prod;

   for (genvar g = 1; g < MUL_STAGES; g++) begin : g_mpipe
      logic [PW-1:0] r_pp;
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) r_pp <= '0;
         else       r_pp <= w_pst[g-1];
      end
      assign w_pst[g] = r_pp;
   end

   assign w_acc = {r_hi, r_lo};

   always_comb begin
      w_mul_res = w_pst[MUL_STAGES-1];
      if (r_op inside {4'd5, 4'd6})      w_mul_res = w_acc + w_pst[MUL_STAGES-1];
      else if (r_op inside {4'd7, 4'd8}) w_mul_res = w_acc - w_pst[MUL_STAGES-1];
   end

   // restoring divide step: r_a shifts dividend out and quotient in
   logic [DATA_W:0]   w_sh;
   logic              w_ge;
   logic [DATA_W-1:0] w_sub, w_q_fix, w_r_fix;

   assign w_sh    = {r_rem, r_a[DATA_W-1]};
   assign w_ge    = w_sh >= {1'b0, r_b};
   assign w_sub   = w_sh[DATA_W-1:0] - r_b;
   assign w_q_fix = r_neg_q ? -r_a : r_a;
   assign w_r_fix = r_neg_r ? -r_rem : r_rem;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fin       = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : (w_is_div ? S_DIV : S_WR);
         S_MUL:  w_fin = (r_cnt == CNT_W'(MUL_STAGES - 1));
         S_DIV:  w_fin = r_dvz || (r_cnt == CNT_W'(DATA_W));
         S_WR:   w_fin = 1'b1;
         default: w_state_nxt = S_IDLE;
      endcase
      if (r_state != S_IDLE && (w_fin || bus.i_cancel)) w_state_nxt = S_IDLE;
   end

   // cancel on the finishing edge suppresses the write and the done pulse
   assign w_write = w_fin && !bus.i_cancel;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op <= '0; r_a <= '0; r_b <= '0; r_rem <= '0; r_opr1 <= '0;
         r_hi <= '0; r_lo <= '0; r_neg_q <= 1'b0; r_neg_r <= 1'b0;
         r_dvz <= 1'b0; r_done <= 1'b0; r_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_op    <= bus.i_op;
            r_a     <= w_abs1;
            r_b     <= w_abs2;
            r_rem   <= '0;
            r_opr1  <= bus.i_opr1;
            r_neg_q <= w_sgn && (bus.i_opr1[DATA_W-1] ^ bus.i_opr2[DATA_W-1]);
            r_neg_r <= w_sgn && bus.i_opr1[DATA_W-1];
            r_dvz   <= (bus.i_opr2 == '0);
            r_cnt   <= '0;
         end else if (r_state != S_IDLE && !bus.i_cancel) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == S_DIV && !w_fin) begin
               r_rem <= w_ge ? w_sub : w_sh[DATA_W-1:0];
               r_a   <= {r_a[DATA_W-2:0], w_ge};
            end
            if (w_write) begin
               r_done <= 1'b1;
               unique case (r_state)
                  S_MUL: {r_hi, r_lo} <= w_mul_res;
                  S_DIV:
                     if (r_dvz) begin
                        r_hi <= r_opr1;
                        r_lo <= '1;
                     end else begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                     end
                  S_WR:
                     if (r_op == 4'd9) r_hi <= r_opr1;
                     else              r_lo <= r_opr1;
                  default: r_done <= 1'b0;
               endcase
            end
         end
      end
   end

   assign bus.o_ready = (r_state == S_IDLE);
   assign bus.o_busy  = (r_state != S_IDLE);
   assign bus.o_done  = r_done;
   assign bus.o_hi    = r_hi;
   assign bus.o_lo    = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vectors for mul_div_unit plus hand sequences for cancel, reset
// and back-to-back issue.
module tb_mul_div_unit;
   localparam int W  = 32;
   localparam int MS = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_div_unit_if #(.DATA_W(W)) bus ();

   mul_div_unit #(.DATA_W(W), .MUL_STAGES(MS)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
      int           lat;
   } vec_t;

   vec_t v [15];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.i_op_valid = 1'b1;
      bus.i_op       = op;
      bus.i_opr1     = a;
      bus.i_opr2     = b;
   endtask

   // issue one op and return the cycle number of its done pulse (-1 on timeout)
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      int guard = 0;
      @(negedge clk);
      while (!bus.o_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      drive(op, a, b);
      @(posedge clk);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      lat = 0;
      while (!bus.o_done && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!bus.o_done) lat = -1;
   endtask

   initial begin
      int  lat;
      bit  seen;
      bus.i_op_valid = 1'b0;
      bus.i_op       = 4'd0;
      bus.i_opr1     = '0;
      bus.i_opr2     = '0;
      bus.i_cancel   = 1'b0;

      //       op     a             b             pre_hi        pre_lo        exp_hi        exp_lo        lat
      v[0]  = '{4'd1,  32'hFFFF_FFFE, 32'h3,        32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MS};
      v[1]  = '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'hFFFF_FFFE, 32'h0000_0001, MS};
      v[2]  = '{4'd6,  32'h1,         32'h1,        32'h0,        32'hFFFF_FFFF, 32'h1,        32'h0,        MS};
      v[3]  = '{4'd8,  32'h1,         32'h1,        32'h1,        32'h0,        32'h0,         32'hFFFF_FFFF, MS};
      v[4]  = '{4'd5,  32'hFFFF_FFFE, 32'h3,        32'h0,        32'hA,        32'h0,         32'h4,        MS};
      v[5]  = '{4'd7,  32'h2,         32'h3,        32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MS};
      v[6]  = '{4'd3,  32'hFFFF_FFF9, 32'h2,        32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, W+1};
      v[7]  = '{4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'h8000_0000, 32'h0,        W+1};
      v[8]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'h0,         32'h8000_0000, W+1};
      v[9]  = '{4'd4,  32'h5,         32'h0,        32'h0,        32'h0,        32'h5,         32'hFFFF_FFFF, 1};
      v[10] = '{4'd3,  32'h7,         32'hFFFF_FFFE, 32'h0,       32'h0,        32'h1,         32'hFFFF_FFFD, W+1};
      v[11] = '{4'd4,  32'd100,       32'd7,        32'h0,        32'h0,        32'h2,         32'hE,        W+1};
      v[12] = '{4'd9,  32'h1234_5678, 32'h0,        32'h0,        32'hAAAA,     32'h1234_5678, 32'hAAAA,     1};
      v[13] = '{4'd10, 32'h55,        32'h0,        32'h1,        32'h2,        32'h1,         32'h55,       1};
      v[14] = '{4'd3,  32'hFFFF_FFFD, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(bus.o_ready), 64'd1);
      chk("rst_busy",  64'(bus.o_busy),  64'd0);
      chk("rst_done",  64'(bus.o_done),  64'd0);
      chk("rst_hilo",  {bus.o_hi, bus.o_lo}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_op(4'd9,  v[i].pre_hi, '0, lat);
         run_op(4'd10, v[i].pre_lo, '0, lat);
         run_op(v[i].op, v[i].a, v[i].b, lat);
         chk($sformatf("v%0d_hi", i),  64'(bus.o_hi), 64'(v[i].exp_hi));
         chk($sformatf("v%0d_lo", i),  64'(bus.o_lo), 64'(v[i].exp_lo));
         chk($sformatf("v%0d_lat", i), 64'(lat),      64'(v[i].lat));
      end

      // DIVU cancelled at cycle 10; a stray op_valid while busy must be ignored
      run_op(4'd9,  32'h1111, '0, lat);
      run_op(4'd10, 32'h2222, '0, lat);
      seen = 1'b0;
      @(negedge clk);
      drive(4'd4, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         seen |= bus.o_done;
         if (c == 5) drive(4'd9, 32'hDEAD, '0);
         if (c == 6) bus.i_op_valid = 1'b0;
      end
      chk("cxl_busy_c10", 64'(bus.o_busy), 64'd1);
      bus.i_cancel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_cancel = 1'b0;
      chk("cxl_ready_c11", 64'(bus.o_ready), 64'd1);
      for (int c = 0; c < 40; c++) begin
         seen |= bus.o_done;
         @(negedge clk);
      end
      chk("cxl_no_done", 64'(seen), 64'd0);
      chk("cxl_hilo", {bus.o_hi, bus.o_lo}, {32'h1111, 32'h2222});

      // cancel on the multiply finishing edge wins
      seen = 1'b0;
      drive(4'd1, 32'd3, 32'd4);
      @(posedge clk);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.i_cancel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_cancel = 1'b0;
      chk("fincxl_ready", 64'(bus.o_ready), 64'd1);
      for (int c = 0; c < 5; c++) begin
         seen |= bus.o_done;
         @(negedge clk);
      end
      chk("fincxl_no_done", 64'(seen), 64'd0);
      chk("fincxl_hilo", {bus.o_hi, bus.o_lo}, {32'h1111, 32'h2222});

      // cancel together with op_valid in IDLE: not accepted
      seen = 1'b0;
      drive(4'd9, 32'hBEEF, '0);
      bus.i_cancel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      bus.i_cancel   = 1'b0;
      chk("idlecxl_ready", 64'(bus.o_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         seen |= bus.o_done;
         @(negedge clk);
      end
      chk("idlecxl_no_done", 64'(seen), 64'd0);
      chk("idlecxl_hi", 64'(bus.o_hi), 64'h1111);

      // MTLO accepted in the done cycle of a MULT
      run_op(4'd1, 32'd3, 32'd4, lat);
      chk("b2b_mul_lat", 64'(lat), 64'(MS));
      chk("b2b_mul_lo", 64'(bus.o_lo), 64'd12);
      chk("b2b_ready_in_done", 64'(bus.o_ready), 64'd1);
      drive(4'd10, 32'd7, '0);
      @(posedge clk);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      chk("b2b_busy", 64'(bus.o_busy), 64'd1);
      chk("b2b_done_1cyc", 64'(bus.o_done), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_done", 64'(bus.o_done), 64'd1);
      chk("b2b_hilo", {bus.o_hi, bus.o_lo}, {32'h0, 32'h7});

      // reset mid-DIV clears immediately and suppresses done
      run_op(4'd9, 32'h99, '0, lat);
      @(negedge clk);
      drive(4'd3, 32'd100, 32'd3);
      @(posedge clk);
      @(negedge clk);
      bus.i_op_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstmid_ready", 64'(bus.o_ready), 64'd1);
      chk("rstmid_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         seen |= bus.o_done;
      end
      chk("rstmid_no_done", 64'(seen), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
